// File: rtl/bldc_commutator.sv
// -----------------------------------------------------------------------------
// bldc_commutator
//   Six-step BLDC commutation sequencer feeding the H-bridge signal generator.
//   Each step drives one high-side/low-side pair for a latched number of
//   cycles. An all-off dead interval follows each step before the next one.
//   The PWM duty is slew-limited to 1 LSB per RAMP_DIV cycles while running.
//
// Ports
//   clk_i          system clock
//   rst_i          asynchronous reset, active-high
//   enable_i       run request; low forces safe (all-off) outputs
//   dir_i          1 = forward (step+1), 0 = reverse (step-1)
//   step_period_i  drive length per step, in cycles (clamped to MIN_PERIOD)
//   duty_target_i  requested PWM duty
//   status_o       bridge enables {Ah,Al,Bh,Bl,Ch,Cl}
//   duty_o         slew-limited duty
//   step_o         current commutation step, 0..5
//   step_tick_o    one-cycle pulse when the step index advances
//   busy_o         high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module bldc_commutator #(
   parameter int DEAD_CYCLES = 2,
   parameter int MIN_PERIOD  = 16,
   parameter int RAMP_DIV    = 100,
   parameter int PERIOD_W    = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                enable_i,
   input  logic                dir_i,
   input  logic [PERIOD_W-1:0] step_period_i,
   input  logic [7:0]          duty_target_i,
   output logic [5:0]          status_o,
   output logic [7:0]          duty_o,
   output logic [2:0]          step_o,
   output logic                step_tick_o,
   output logic                busy_o
);

   localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(RAMP_DIV - 1);
   localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD);
   localparam logic [PERIOD_W-1:0] DEAD_LAST = PERIOD_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DEAD} state_t;

   state_t              state_q, state_d;
   logic [2:0]          step_q, step_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [PERIOD_W-1:0] plen_q, plen_d;
   logic [5:0]          status_q, status_d;
   logic [7:0]          duty_q, duty_d;
   logic [PRE_W-1:0]    pre_q, pre_d;
   logic                tick_q, tick_d;
   logic                busy_q, busy_d;

   logic [2:0]          next_step;
   logic [PERIOD_W-1:0] plen_new;
   logic                advance;

   function automatic logic [5:0] step_status(input logic [2:0] s);
      case (s)
         3'd0:    step_status = 6'b100100;
         3'd1:    step_status = 6'b100001;
         3'd2:    step_status = 6'b001001;
         3'd3:    step_status = 6'b011000;
         3'd4:    step_status = 6'b010010;
         3'd5:    step_status = 6'b000110;
         default: step_status = 6'b000000;
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      cnt_d    = cnt_q;
      plen_d   = plen_q;
      status_d = status_q;
      duty_d   = duty_q;
      pre_d    = pre_q;
      tick_d   = 1'b0;
      busy_d   = busy_q;
      advance  = 1'b0;

      if (dir_i) next_step = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
      else       next_step = (step_q == 3'd0) ? 3'd5 : step_q - 3'd1;

      plen_new = (step_period_i < MIN_P) ? MIN_P : step_period_i;

      // Duty ramp: prescaler only advances while running; clamped by the
      // compare so duty can never step past the target or out of range.
      if (busy_q) begin
         if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (duty_q < duty_target_i)      duty_d = duty_q + 8'd1;
            else if (duty_q > duty_target_i) duty_d = duty_q - 8'd1;
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            status_d = '0;
            busy_d   = 1'b0;
            duty_d   = '0;
            pre_d    = '0;
            if (enable_i) begin
               state_d  = S_DRIVE;
               status_d = step_status(step_q);
               cnt_d    = '0;
               plen_d   = plen_new;
               busy_d   = 1'b1;
            end
         end
         S_DRIVE: begin
            if (enable_i) begin
               if (cnt_q == plen_q - PERIOD_W'(1)) begin
                  if (DEAD_CYCLES > 0) begin
                     state_d  = S_DEAD;
                     status_d = '0;
                     cnt_d    = '0;
                  end else begin
                     advance = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + PERIOD_W'(1);
               end
            end
         end
         S_DEAD: begin
            if (enable_i) begin
               if (cnt_q == DEAD_LAST) advance = 1'b1;
               else                    cnt_d = cnt_q + PERIOD_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A new step starts a fresh drive phase with a freshly latched period;
      // dir_i is sampled only here, so direction never changes mid-step.
      if (advance) begin
         state_d  = S_DRIVE;
         step_d   = next_step;
         tick_d   = 1'b1;
         status_d = step_status(next_step);
         cnt_d    = '0;
         plen_d   = plen_new;
      end

      // Dropping enable while running is immediately safe; step is retained.
      if (!enable_i && state_q != S_IDLE) begin
         state_d  = S_IDLE;
         status_d = '0;
         busy_d   = 1'b0;
         duty_d   = '0;
         pre_d    = '0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         step_q   <= '0;
         cnt_q    <= '0;
         plen_q   <= '0;
         status_q <= '0;
         duty_q   <= '0;
         pre_q    <= '0;
         tick_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         cnt_q    <= cnt_d;
         plen_q   <= plen_d;
         status_q <= status_d;
         duty_q   <= duty_d;
         pre_q    <= pre_d;
         tick_q   <= tick_d;
         busy_q   <= busy_d;
      end
   end

   assign status_o    = status_q;
   assign duty_o      = duty_q;
   assign step_o      = step_q;
   assign step_tick_o = tick_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_bldc_commutator.sv
// -----------------------------------------------------------------------------
// tb_bldc_commutator
//   Directed + randomized bench for bldc_commutator. A behavioural model
//   (segment countdown, modular step arithmetic, ideal duty ramp) predicts
//   every output each cycle; safety invariants are checked alongside.
// -----------------------------------------------------------------------------
module tb_bldc_commutator;

   localparam int DEAD = 2;
   localparam int MINP = 16;
   localparam int RDIV = 4;
   localparam int PW   = 16;

   logic          clk = 1'b0;
   logic          rst, en, dir;
   logic [PW-1:0] per;
   logic [7:0]    tgt;
   logic [5:0]    status_o;
   logic [7:0]    duty_o;
   logic [2:0]    step_o;
   logic          step_tick_o, busy_o;

   bldc_commutator #(
      .DEAD_CYCLES(DEAD), .MIN_PERIOD(MINP), .RAMP_DIV(RDIV), .PERIOD_W(PW)
   ) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(en), .dir_i(dir),
      .step_period_i(per), .duty_target_i(tgt),
      .status_o(status_o), .duty_o(duty_o), .step_o(step_o),
      .step_tick_o(step_tick_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   logic [5:0] tbl [6] = '{6'b100100, 6'b100001, 6'b001001,
                           6'b011000, 6'b010010, 6'b000110};
   bit   m_run, m_dead, m_tick;
   int   m_step, m_left, m_duty, m_pre;
   logic [5:0] prev_status;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int plen_of(input int p);
      return (p < MINP) ? MINP : p;
   endfunction

   task automatic model_reset();
      m_run = 0; m_dead = 0; m_tick = 0;
      m_step = 0; m_left = 0; m_duty = 0; m_pre = 0;
      prev_status = '0;
   endtask

   // One clock edge of the reference behaviour, using the inputs that were
   // stable before the edge.
   task automatic model_edge();
      m_tick = 0;
      if (!en) begin
         m_run = 0; m_dead = 0; m_duty = 0; m_pre = 0;
      end else if (!m_run) begin
         m_run = 1; m_dead = 0; m_left = plen_of(int'(per));
      end else begin
         m_pre++;
         if (m_pre == RDIV) begin
            m_pre = 0;
            if (m_duty < int'(tgt))      m_duty++;
            else if (m_duty > int'(tgt)) m_duty--;
         end
         m_left--;
         if (m_left == 0) begin
            if (!m_dead && DEAD > 0) begin
               m_dead = 1; m_left = DEAD;
            end else begin
               m_dead = 0;
               m_step = (m_step + (dir ? 1 : 5)) % 6;
               m_tick = 1;
               m_left = plen_of(int'(per));
            end
         end
      end
   endtask

   task automatic check_outputs();
      logic [5:0] exp_status;
      logic       overlap, jump;
      exp_status = (m_run && !m_dead) ? tbl[m_step] : 6'b0;
      chk("status", 32'(status_o), 32'(exp_status));
      chk("duty",   32'(duty_o),   32'(m_duty));
      chk("step",   32'(step_o),   32'(m_step));
      chk("tick",   32'(step_tick_o), 32'(m_tick));
      chk("busy",   32'(busy_o),   32'(m_run));
      overlap = (status_o[5] & status_o[4]) | (status_o[3] & status_o[2]) |
                (status_o[1] & status_o[0]);
      jump = (prev_status != 6'b0) && (status_o != 6'b0) && (status_o != prev_status);
      chk("phase_overlap", 32'(overlap), 32'(0));
      chk("direct_switch", 32'(jump), 32'(0));
      prev_status = status_o;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         model_edge();
         #1;
         check_outputs();
      end
   endtask

   // Asynchronous reset asserted between edges; outputs must clear at once.
   task automatic async_reset_check();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_status", 32'(status_o), 32'(0));
      chk("arst_duty",   32'(duty_o),   32'(0));
      chk("arst_step",   32'(step_o),   32'(0));
      chk("arst_tick",   32'(step_tick_o), 32'(0));
      chk("arst_busy",   32'(busy_o),   32'(0));
      model_reset();
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int k;
      rst = 1'b1; en = 1'b0; dir = 1'b1; per = 16'd20; tgt = 8'd5;
      model_reset();
      #12;
      check_outputs();          // reset state
      rst = 1'b0;

      // forward rotation, period 20, duty ramp to 5 then down to 2
      en = 1'b1;
      cyc(6 * 22 + 12);
      tgt = 8'd2;
      cyc(20);

      // reset mid-drive, then reverse from step 0; toggle dir mid-drive
      async_reset_check();
      dir = 1'b0;
      cyc(3 * 22 + 5);
      dir = 1'b1;
      cyc(4);
      dir = 1'b0;
      cyc(30);

      // period clamp, then mid-step period change 20 -> 40
      per = 16'd3;
      cyc(40);
      per = 16'd20;
      k = 0;
      while (!m_tick && k < 100) begin cyc(1); k++; end
      chk("tick_seen", 32'(step_tick_o), 32'(1));
      cyc(5);
      per = 16'd40;
      cyc(70);

      // drop enable during step 3, then resume
      dir = 1'b1;
      k = 0;
      while (!(m_step == 3 && m_run && !m_dead) && k < 400) begin cyc(1); k++; end
      chk("reach_step3", 32'(step_o), 32'(3));
      cyc(3);
      en = 1'b0;
      cyc(1);
      chk("idle_status", 32'(status_o), 32'(0));
      chk("idle_step",   32'(step_o),   32'(3));
      chk("idle_busy",   32'(busy_o),   32'(0));
      cyc(3);
      en = 1'b1;
      cyc(1);
      chk("resume_status", 32'(status_o), 32'(6'b011000));
      cyc(45);

      // randomized enable/dir/period/target
      for (int i = 0; i < 1500; i++) begin
         en = ($urandom_range(0, 39) != 0);
         if ($urandom_range(0, 49) == 0) dir = $urandom_range(0, 1);
         if ($urandom_range(0, 9) == 0)  per = PW'($urandom_range(0, 30));
         if ($urandom_range(0, 99) == 0) tgt = 8'($urandom_range(0, 255));
         cyc(1);
      end

      en = 1'b1;
      cyc(30);
      async_reset_check();
      cyc(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
